visfinal: RTL and testbench

Final-stage visibility accumulator for the correlator pipeline. It receives a stream of NSUMS interleaved partial visibilities (IBITS wide) from the upstream correlator and sums each interleaved channel across all blocks of one frame. It then emits the NSUMS completed OBITS-wide visibilities as a framed stream for the downstream readout/bus logic.

---
 rtl/visfinal_pkg.sv | 7 +
 rtl/visfinal_acc.sv | 18 +
 rtl/visfinal.sv | 57 +++++
 tb/tb_visfinal.sv | 130 +++++++++++++
 4 files changed

// File: rtl/visfinal_pkg.sv
// visfinal_pkg: default geometry for the final-stage visibility accumulator.
package visfinal_pkg;
  localparam int DEF_IBITS = 5;
  localparam int DEF_OBITS = 8;
  localparam int DEF_NSUMS = 4;
  localparam int DEF_ABITS = 2;
endpackage

// File: rtl/visfinal_acc.sv
// visfinal_acc: NSUMS x OBITS accumulator register file, one async read port and one write port.
module visfinal_acc #(
  parameter int OBITS = 8,
  parameter int NSUMS = 4,
  parameter int ABITS = 2
) (
  input  logic             clock_i,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [OBITS-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [OBITS-1:0] rdata
);
  logic [OBITS-1:0] mem [NSUMS];
  assign rdata = mem[raddr];
  always_ff @(posedge clock_i)
    if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/visfinal.sv
// visfinal: sums NSUMS interleaved partial visibilities across the blocks of a frame
// and emits the completed set as a framed stream with one cycle of latency.
module visfinal
  import visfinal_pkg::*;
#(
  parameter int IBITS = DEF_IBITS,
  parameter int OBITS = DEF_OBITS,
  parameter int NSUMS = DEF_NSUMS,
  parameter int ABITS = DEF_ABITS
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [IBITS-1:0] data_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic [OBITS-1:0] data_o
);
  if (NSUMS != (1 << ABITS)) begin : g_bad_nsums
    $error("visfinal: NSUMS must equal 2**ABITS");
  end
  if (OBITS < IBITS) begin : g_bad_obits
    $error("visfinal: OBITS must be at least IBITS");
  end
  logic [ABITS-1:0] addr;
  logic [OBITS-1:0] rd_data;
  logic [OBITS-1:0] sum;
  logic             take_last;
  // A first beat restarts the channel from zero, so one adder serves all three beat kinds.
  assign sum       = (first_i ? '0 : rd_data) + OBITS'(data_i);
  assign take_last = valid_i & last_i;
  visfinal_acc #(.OBITS(OBITS), .NSUMS(NSUMS), .ABITS(ABITS)) u_acc (
    .clock_i(clock_i),
    .we     (valid_i),
    .waddr  (addr),
    .wdata  (sum),
    .raddr  (addr),
    .rdata  (rd_data)
  );
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      addr    <= '0;
      valid_o <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      if (valid_i) addr <= addr + ABITS'(1);
      valid_o <= take_last;
      first_o <= take_last && addr == '0;
      last_o  <= take_last && addr == ABITS'(NSUMS - 1);
      if (take_last) data_o <= sum;
    end
endmodule

// File: tb/tb_visfinal.sv
// tb_visfinal: directed self-checking bench for visfinal with hand-computed sums.
module tb_visfinal;
  logic       clock_i = 1'b0;
  logic       reset_ni;
  logic       valid_i, first_i, last_i;
  logic [4:0] data_i;
  logic       valid_o, first_o, last_o;
  logic [7:0] data_o;
  int checks = 0;
  int errors = 0;
  int bch = 0;
  int out_cnt = 0;
  logic [7:0] exp_hold = '0;
  logic [7:0] m [4];
  visfinal #(.IBITS(5), .OBITS(8), .NSUMS(4), .ABITS(2)) dut (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .valid_i (valid_i),
    .first_i (first_i),
    .last_i  (last_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .first_o (first_o),
    .last_o  (last_o),
    .data_o  (data_o)
  );
  always #5 clock_i = ~clock_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_i);
      #1;
      chk("idle_valid", 32'(valid_o), 0);
      chk("idle_flags", {first_o, last_o}, 0);
      chk("idle_hold", 32'(data_o), 32'(exp_hold));
    end
  endtask
  task automatic beat(input logic f, input logic l, input logic [4:0] d, input logic [7:0] expd);
    valid_i = 1'b1;
    first_i = f;
    last_i  = l;
    data_i  = d;
    @(posedge clock_i);
    #1;
    valid_i = 1'b0;
    first_i = 1'bx;
    last_i  = 1'bx;
    data_i  = 'x;
    if (valid_o === 1'b1) out_cnt++;
    chk("beat_valid", 32'(valid_o), 32'(l));
    if (l) begin
      exp_hold = expd;
      chk("out_data", 32'(data_o), 32'(expd));
      chk("out_first", 32'(first_o), 32'(bch == 0));
      chk("out_last", 32'(last_o), 32'(bch == 3));
    end else begin
      chk("beat_flags", {first_o, last_o}, 0);
      chk("beat_hold", 32'(data_o), 32'(exp_hold));
    end
    bch = (bch + 1) % 4;
  endtask
  // dv packs ch0 in the low 5 bits; ev packs ch0's expected sum in the low byte.
  task automatic run_frame(input int nb, input logic [19:0] dv, input logic [31:0] ev, input bit gaps);
    out_cnt = 0;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 4; c++) begin
        beat(b == 0, b == nb - 1, dv[c*5 +: 5], ev[c*8 +: 8]);
        if (gaps) idle($urandom_range(0, 2));
      end
    chk("out_count", 32'(out_cnt), 4);
  endtask
  initial begin
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    first_i  = 1'b0;
    last_i   = 1'b0;
    data_i   = '0;
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_flags", {first_o, last_o}, 0);
    chk("rst_data", 32'(data_o), 0);
    repeat (2) @(posedge clock_i);
    #1;
    reset_ni = 1'b1;
    idle(1);
    run_frame(8, 20'hFFFFF, 32'hF8F8F8F8, 1'b0);
    run_frame(8, {5'd4, 5'd3, 5'd2, 5'd1}, {8'd32, 8'd24, 8'd16, 8'd8}, 1'b0);
    idle(2);
    run_frame(16, 20'hFFFFF, 32'hF0F0F0F0, 1'b0);
    run_frame(1, {5'd8, 5'd7, 5'd6, 5'd5}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0);
    out_cnt = 0;
    for (int b = 0; b < 5; b++)
      for (int c = 0; c < 4; c++) begin
        logic [4:0] d;
        d = 5'($urandom_range(0, 31));
        m[c] = (b == 0) ? 8'(d) : m[c] + 8'(d);
        beat(b == 0, b == 4, d, m[c]);
        idle($urandom_range(0, 2));
      end
    chk("rand_count", 32'(out_cnt), 4);
    run_frame(2, {5'd10, 5'd20, 5'd30, 5'd1}, {8'd20, 8'd40, 8'd60, 8'd2}, 1'b0);
    run_frame(1, {5'd9, 5'd9, 5'd9, 5'd9}, 32'h09090909, 1'b0);
    out_cnt = 0;
    for (int i = 0; i < 4; i++) beat(i == 0, 1'b0, 5'd3, 8'd0);
    beat(1'b0, 1'b0, 5'd3, 8'd0);
    beat(1'b0, 1'b0, 5'd3, 8'd0);
    reset_ni = 1'b0;
    #1;
    chk("async_valid", 32'(valid_o), 0);
    chk("async_flags", {first_o, last_o}, 0);
    chk("async_data", 32'(data_o), 0);
    chk("abort_count", 32'(out_cnt), 0);
    exp_hold = '0;
    bch = 0;
    @(posedge clock_i);
    #1;
    reset_ni = 1'b1;
    idle(1);
    run_frame(2, {5'd4, 5'd3, 5'd2, 5'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 1'b0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
